// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and constants for the data memory controller.
//   state_t    : controller FSM states
//   DMEM_INIT0 : power-up contents of word 0 (all other words power up as 0)
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [15:0] DMEM_INIT0 = 16'h00F0;

endpackage

// File: rtl/data_memory_ctrl_array.sv
// dmem_array: DEPTH x DATA_W storage with per-byte-lane write enables,
// edge-triggered write and registered read. No reset; contents power up
// with word 0 = DMEM_INIT0 and every other word = 0.
//   clk   : clock
//   en    : perform an access this edge (read data register updates)
//   we    : byte-lane write enables, one bit per 8-bit lane
//   idx   : word index
//   wdata : write data
//   rdata : registered read data (word contents before any same-edge write)
module dmem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned BE_W   = DATA_W / 8,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic [BE_W-1:0]   we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH] = '{0: DATA_W'(DMEM_INIT0), default: {DATA_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: valid/ready wrapper around dmem_array with programmable
// wait states, byte-lane stores and an out-of-range error response.
//   clk, reset           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only while IDLE)
//   req_write            : 1 = store, 0 = load
//   req_addr/wdata/be    : word address, store data, byte-lane enables
//   rsp_valid/rsp_ready  : response handshake, held until accepted
//   rsp_rdata            : load data (0 for stores and errors)
//   rsp_err              : request address was >= DEPTH
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              enter;

  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              in_range;

  logic              rd_ok, err_q;
  logic [DATA_W-1:0] arr_rdata;

  // With zero wait states the access happens on the accept edge itself, so
  // the live request fields are used; otherwise the latched copy is used.
  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_be    = lat_be;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  // Full address compared against DEPTH so upper bits never alias.
  assign in_range = ({1'b0, acc_addr} < DEPTH_X);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    enter   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_n = RESP;
            enter   = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = RESP;
          enter   = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rd_ok     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && req_valid) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      if (enter) begin
        rd_ok <= in_range && !acc_write;
        err_q <= !in_range;
      end
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .BE_W   (BE_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (enter && in_range),
    .we    (acc_write ? acc_be : '0),
    .idx   (acc_addr[IDX_W-1:0]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = ((state == RESP) && rd_ok) ? arr_rdata : '0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid0, valid3, validz;
  logic        req_write;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_be;
  logic        rsp_ready;

  logic        ready0, rv0, er0;
  logic [15:0] rd0;
  logic        ready3, rv3, er3;
  logic [15:0] rd3;
  logic        readyz, rvz, erz;
  logic [15:0] rdz;

  data_memory_ctrl u_dut0 (
    .clk(clk), .reset(reset), .req_valid(valid0), .req_ready(ready0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(er0)
  );

  data_memory_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(valid3), .req_ready(ready3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_rdata(rd3), .rsp_err(er3)
  );

  data_memory_ctrl #(.WAIT_CYCLES(0)) u_dutz (
    .clk(clk), .reset(reset), .req_valid(validz), .req_ready(readyz),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rvz), .rsp_ready(rsp_ready), .rsp_rdata(rdz), .rsp_err(erz)
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  logic [15:0] model [16];
  logic [16:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for an accepted request on the default instance.
  task automatic push_expect(input logic w, input logic [15:0] a, input logic [15:0] d,
                             input logic [1:0] be);
    if (a >= 16) begin
      sb.push_back({1'b1, 16'h0000});
    end else if (w) begin
      for (int i = 0; i < 2; i++) if (be[i]) model[a[3:0]][8*i +: 8] = d[8*i +: 8];
      sb.push_back({1'b0, 16'h0000});
    end else begin
      sb.push_back({1'b0, model[a[3:0]]});
    end
  endtask

  task automatic pop_check(input string tag);
    logic [16:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_rdata"}, rd0, e[15:0]);
      check({tag, "_err"}, er0, e[16]);
    end
  endtask

  // Full transaction on the default instance; called and returns at a negedge.
  task automatic txn(input string tag, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [1:0] be);
    int unsigned lat;
    req_write = w; req_addr = a; req_wdata = d; req_be = be; valid0 = 1'b1;
    check({tag, "_req_ready"}, ready0, 1'b1);
    @(posedge clk);
    push_expect(w, a, d, be);
    @(negedge clk);
    valid0 = 1'b0;
    req_addr = 16'hxxxx; req_wdata = 16'hxxxx;
    lat = 1;
    while (!rv0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    pop_check(tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_after"}, ready0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    model[0] = 16'h00F0;
    reset = 1'b0; valid0 = 1'b0; valid3 = 1'b0; validz = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rv0, 1'b0);
    check("rst_rsp_rdata", rd0, 16'h0000);
    check("rst_rsp_err", er0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", ready0, 1'b1);

    txn("reset_read", 1'b0, 16'd0, 16'h0000, 2'b00);
    txn("st_beef", 1'b1, 16'd5, 16'hBEEF, 2'b11);
    txn("ld_beef", 1'b0, 16'd5, 16'h0000, 2'b00);
    txn("st_lo", 1'b1, 16'd5, 16'h1234, 2'b01);
    txn("ld_be34", 1'b0, 16'd5, 16'h0000, 2'b00);
    txn("st_be0", 1'b1, 16'd5, 16'hFFFF, 2'b00);
    txn("st_oor", 1'b1, 16'd16, 16'hDEAD, 2'b11);
    txn("ld_addr0", 1'b0, 16'd0, 16'h0000, 2'b00);
    txn("ld_oor", 1'b0, 16'd16, 16'h0000, 2'b00);
    txn("st_hi", 1'b1, 16'd15, 16'hA55A, 2'b10);
    txn("ld_hi", 1'b0, 16'd15, 16'h0000, 2'b00);

    // Back-pressure on a load of addr 5.
    rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = 16'd5; valid0 = 1'b1;
    @(posedge clk);
    push_expect(1'b0, 16'd5, 16'h0000, 2'b00);
    @(negedge clk);
    valid0 = 1'b0;
    lat = 1;
    while (!rv0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 2);
    for (int k = 0; k < 4; k++) begin
      check("bp_rsp_valid", rv0, 1'b1);
      check("bp_rsp_rdata", rd0, 16'hBE34);
      check("bp_req_ready", ready0, 1'b0);
      @(negedge clk);
    end
    pop_check("bp");
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_req_ready_after", ready0, 1'b1);
    check("bp_rsp_valid_after", rv0, 1'b0);

    // Wait-state variants: 3 and 0.
    req_write = 1'b0; req_addr = 16'd0; valid3 = 1'b1;
    check("w3_req_ready", ready3, 1'b1);
    @(posedge clk);
    @(negedge clk);
    valid3 = 1'b0;
    lat = 1;
    while (!rv3 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w3_latency", lat, 4);
    check("w3_rdata", rd3, 16'h00F0);
    check("w3_err", er3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("w3_req_ready_after", ready3, 1'b1);

    req_addr = 16'd0; validz = 1'b1;
    @(posedge clk);
    @(negedge clk);
    validz = 1'b0;
    lat = 1;
    while (!rvz && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w0_latency", lat, 1);
    check("w0_rdata", rdz, 16'h00F0);
    check("w0_err", erz, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("w0_req_ready_after", readyz, 1'b1);

    // Reset during WAIT of a store: the store must be dropped.
    req_write = 1'b1; req_addr = 16'd2; req_wdata = 16'hAAAA; req_be = 2'b11; valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid0 = 1'b0;
    check("rw_in_wait_valid", rv0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rw_rsp_valid", rv0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rw_req_ready", ready0, 1'b1);
    txn("rw_ld_addr2", 1'b0, 16'd2, 16'h0000, 2'b00);

    // Reset while a response is held: valid must fall without a clock edge.
    rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = 16'd5; valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid0 = 1'b0;
    lat = 1;
    while (!rv0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rr_latency", lat, 2);
    reset = 1'b0;
    #1;
    check("rr_rsp_valid", rv0, 1'b0);
    check("rr_rsp_rdata", rd0, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rr_req_ready", ready0, 1'b1);
    txn("rr_ld_addr5", 1'b0, 16'd5, 16'h0000, 2'b00);

    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
